// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader: FSM state encoding,
// the default frame header byte and the XOR-reduce checksum helper.
package fir_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CHECK  = 3'd2,
      COMMIT = 3'd3,
      DONE   = 3'd4
   } loader_state_e;

   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

   // Upper bound on frame size accepted by the checksum helper; unused
   // high bytes are zero-padded and do not disturb the XOR.
   localparam int MAX_COEFF = 64;

   function automatic logic [7:0] xor_reduce(input logic [MAX_COEFF*8-1:0] bytes_i);
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < MAX_COEFF; i++) begin
         acc = acc ^ bytes_i[i*8 +: 8];
      end
      return acc;
   endfunction

endpackage

// File: rtl/coeff_shadow_bank.sv
// Shadow buffer of NUM_COEFF bytes that holds a frame until it is complete.
// Written one byte at a time by index, read back through an index mux.
// With FIR_COEFF_LOADER_CHECKSUM_EN defined the whole buffer is also exposed
// flat so the loader can compute the frame checksum.
module coeff_shadow_bank #(
   parameter  int NUM_COEFF = 4,
   localparam int IDXW      = $clog2(NUM_COEFF)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en_i,
   input  logic [IDXW-1:0]        wr_idx_i,
   input  logic [7:0]             wr_data_i,
   input  logic [IDXW-1:0]        rd_idx_i,
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
   output logic [NUM_COEFF*8-1:0] flat_o,
`endif
   output logic [7:0]             rd_data_o
);

   logic [7:0] shadow_q [NUM_COEFF];

   // Byte storage: cleared on reset, otherwise overwritten only by frame data.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_COEFF; i++) begin
            shadow_q[i] <= '0;
         end
      end else if (wr_en_i && (int'(wr_idx_i) < NUM_COEFF)) begin
         shadow_q[wr_idx_i] <= wr_data_i;
      end
   end

   // Read mux; out-of-range indices (non power-of-two sizes) read as zero.
   always_comb begin
      rd_data_o = '0;
      if (int'(rd_idx_i) < NUM_COEFF) begin
         rd_data_o = shadow_q[rd_idx_i];
      end
   end

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
   // Flattened view of the buffer for checksum computation.
   always_comb begin
      flat_o = '0;
      for (int i = 0; i < NUM_COEFF; i++) begin
         flat_o[i*8 +: 8] = shadow_q[i];
      end
   end
`endif

endmodule

// File: rtl/fir_coeff_loader.sv
// Byte-stream coefficient loader feeding the FIR coefficient register bank.
// Hunts for HEADER, buffers NUM_COEFF bytes, then commits them as a burst of
// single-cycle write strobes so the filter only ever sees complete frames.
// Optional feature macro: FIR_COEFF_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte (CHECK state) and a sticky err flag; otherwise err is 0.
//
// Handshake: a byte moves on every cycle where in_valid && in_ready; in_ready
// is a register driven purely from the FSM, never from in_valid.
module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter  int         NUM_COEFF = 4,
   parameter  int         SIZE      = 8,
   parameter  logic [7:0] HEADER    = DEFAULT_HEADER,
   localparam int         SELW      = $clog2(NUM_COEFF)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [SIZE-1:0] coeff_out,
   output logic [SELW-1:0] coeff_sel,
   output logic            coeff_we,
   output logic            busy,
   output logic            done,
   output logic            err,
   output loader_state_e   dbg_state
);

   localparam logic [SELW-1:0] LAST = SELW'(NUM_COEFF - 1);

   loader_state_e   state_q;
   logic [SELW-1:0] idx_q;
   logic [SELW-1:0] sel_q;
   logic [SIZE-1:0] out_q;
   logic            we_q;
   logic            in_ready_q;
   logic            busy_q;
   logic            done_q;
   logic [SELW-1:0] rd_idx_d;
   logic [7:0]      rd_data;
   logic            accept;

   assign accept = in_valid && in_ready_q;

   // Commit reads one entry ahead of the registered select; otherwise entry 0.
   always_comb begin
      rd_idx_d = '0;
      if (state_q == COMMIT) begin
         rd_idx_d = sel_q + SELW'(1);
      end
   end

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
   logic [NUM_COEFF*8-1:0] shadow_flat;
   logic [MAX_COEFF*8-1:0] shadow_padded;
   logic [7:0]             csum;
   logic                   err_q;

   // Zero-extend the buffer to the helper's fixed width.
   always_comb begin
      shadow_padded = '0;
      shadow_padded[NUM_COEFF*8-1:0] = shadow_flat;
   end

   assign csum = xor_reduce(shadow_padded);
   assign err  = err_q;
`else
   assign err = 1'b0;
`endif

   coeff_shadow_bank #(.NUM_COEFF(NUM_COEFF)) u_shadow (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (accept && (state_q == LOAD)),
      .wr_idx_i  (idx_q),
      .wr_data_i (in_data),
      .rd_idx_i  (rd_idx_d),
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
      .flat_o    (shadow_flat),
`endif
      .rd_data_o (rd_data)
   );

   // Loader FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         sel_q      <= '0;
         out_q      <= '0;
         we_q       <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
         err_q      <= 1'b0;
`endif
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (accept && (in_data == HEADER)) begin
                  state_q <= LOAD;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
                  err_q   <= 1'b0;
`endif
               end
            end
            LOAD: begin
               if (accept) begin
                  idx_q <= idx_q + SELW'(1);
                  if (idx_q == LAST) begin
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
                     state_q <= CHECK;
`else
                     state_q    <= COMMIT;
                     in_ready_q <= 1'b0;
                     we_q       <= 1'b1;
                     sel_q      <= '0;
                     out_q      <= rd_data[SIZE-1:0];
`endif
                  end
               end
            end
            CHECK: begin
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
               if (accept) begin
                  if (in_data == csum) begin
                     state_q    <= COMMIT;
                     in_ready_q <= 1'b0;
                     we_q       <= 1'b1;
                     sel_q      <= '0;
                     out_q      <= rd_data[SIZE-1:0];
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     err_q   <= 1'b1;
                  end
               end
`else
               state_q <= IDLE;
               busy_q  <= 1'b0;
`endif
            end
            COMMIT: begin
               if (sel_q == LAST) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  we_q  <= 1'b1;
                  sel_q <= sel_q + SELW'(1);
                  out_q <= rd_data[SIZE-1:0];
               end
            end
            DONE: begin
               state_q    <= IDLE;
               busy_q     <= 1'b0;
               in_ready_q <= 1'b1;
            end
            default: begin
               state_q    <= IDLE;
               busy_q     <= 1'b0;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign coeff_out = out_q;
   assign coeff_sel = sel_q;
   assign coeff_we  = we_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader (NUM_COEFF=4, SIZE=8, HEADER=A5).
// Frames get an XOR checksum byte appended when
// FIR_COEFF_LOADER_CHECKSUM_EN is defined.
module tb_fir_coeff_loader;
   import fir_pkg::*;

   logic          clk;
   logic          rst;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    coeff_out;
   logic [1:0]    coeff_sel;
   logic          coeff_we;
   logic          busy;
   logic          done;
   logic          err;
   loader_state_e dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [9:0] exp_q[$];
   logic [9:0] act_q[$];
   int         done_cnt;

   fir_coeff_loader #(.NUM_COEFF(4), .SIZE(8), .HEADER(8'hA5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .coeff_out (coeff_out),
      .coeff_sel (coeff_sel),
      .coeff_we  (coeff_we),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // write monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (coeff_we) act_q.push_back({coeff_sel, coeff_out});
      if (done) done_cnt++;
   end

   // driver: present a byte from a falling edge, hold until accepted
   task automatic send_byte(input logic [7:0] b);
      int n;
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d0, d1, d2, d3);
      send_byte(8'hA5);
      send_byte(d0);
      send_byte(d1);
      send_byte(d2);
      send_byte(d3);
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
      send_byte(d0 ^ d1 ^ d2 ^ d3);
`endif
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (!done) begin
         n_fail++;
         $display("FAIL done_timeout: done=%0b, required 1", done);
      end
      @(negedge clk);
   endtask

   task automatic clear_logs();
      act_q.delete();
      exp_q.delete();
      done_cnt = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, coeff_we, busy, done, err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: rdy/we/busy/done/err=%b, required 00000",
                  {in_ready, coeff_we, busy, done, err});
      end
      n_cmp++;
      if ({coeff_sel, coeff_out} !== 10'h0) begin
         n_fail++;
         $display("FAIL reset_data: sel=%0d out=%h, required 0 00", coeff_sel, coeff_out);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%0b state=%0d, required 1 IDLE", in_ready, dbg_state);
      end
   endtask

   // cycle-exact commit timing after the last frame byte
   task automatic test_basic();
      logic [7:0] exp_v[4];
      exp_v = '{8'h01, 8'h02, 8'h03, 8'h04};
      clear_logs();
      send_frame(8'h01, 8'h02, 8'h03, 8'h04);
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (coeff_we !== 1'b1 || coeff_sel !== 2'(k) || coeff_out !== exp_v[k]) begin
            n_fail++;
            $display("FAIL basic_write%0d: we=%0b sel=%0d out=%h, required 1 %0d %h",
                     k, coeff_we, coeff_sel, coeff_out, k, exp_v[k]);
         end
         n_cmp++;
         if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_commit_flags%0d: in_ready=%0b busy=%0b, required 0 1", k, in_ready, busy);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (done !== 1'b1 || coeff_we !== 1'b0 || in_ready !== 1'b0 || coeff_out !== 8'h04) begin
         n_fail++;
         $display("FAIL basic_done: done=%0b we=%0b rdy=%0b out=%h, required 1 0 0 04",
                  done, coeff_we, in_ready, coeff_out);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_idle: done=%0b busy=%0b rdy=%0b err=%0b, required 0 0 1 0",
                  done, busy, in_ready, err);
      end
      n_cmp++;
      if (done_cnt !== 1) begin
         n_fail++;
         $display("FAIL basic_done_count: %0d pulses, required 1", done_cnt);
      end
   endtask

   task automatic test_discard();
      clear_logs();
      send_byte(8'h00);
      send_byte(8'hFF);
      n_cmp++;
      if (busy !== 1'b0 || dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL discard_idle: busy=%0b state=%0d, required 0 IDLE", busy, dbg_state);
      end
      send_frame(8'h10, 8'h20, 8'h30, 8'h40);
      wait_done();
      exp_q = '{{2'd0, 8'h10}, {2'd1, 8'h20}, {2'd2, 8'h30}, {2'd3, 8'h40}};
      n_cmp++;
      if (act_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL discard_count: %0d writes, required %0d", act_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL discard_write%0d: got %h, required %h", i, act_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_gap();
      clear_logs();
      send_byte(8'hA5);
      send_byte(8'h11);
      send_byte(8'h22);
      in_valid = 1'b0;
      in_data  = 8'h77;
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (dbg_state !== LOAD || in_ready !== 1'b1 || coeff_we !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_wait%0d: state=%0d rdy=%0b we=%0b, required LOAD 1 0",
                     c, dbg_state, in_ready, coeff_we);
         end
         @(negedge clk);
      end
      send_byte(8'h33);
      send_byte(8'h44);
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
      send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`endif
      in_valid = 1'b0;
      wait_done();
      exp_q = '{{2'd0, 8'h11}, {2'd1, 8'h22}, {2'd2, 8'h33}, {2'd3, 8'h44}};
      n_cmp++;
      if (act_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL gap_count: %0d writes, required %0d", act_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL gap_write%0d: got %h, required %h", i, act_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_header_as_data();
      clear_logs();
      send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5);
      wait_done();
      exp_q = '{{2'd0, 8'hA5}, {2'd1, 8'hA5}, {2'd2, 8'hA5}, {2'd3, 8'hA5}};
      n_cmp++;
      if (act_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL hdrdata_count: %0d writes, required %0d", act_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL hdrdata_write%0d: got %h, required %h", i, act_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_commit();
      clear_logs();
      send_frame(8'h01, 8'h02, 8'h03, 8'h04);
      // now in the sel=0 write cycle; advance to the sel=1 write cycle
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({in_ready, coeff_we, busy, done, err} !== 5'b0 || {coeff_sel, coeff_out} !== 10'h0) begin
         n_fail++;
         $display("FAIL midrst_outputs: rdy/we/busy/done/err=%b sel=%0d out=%h, required 00000 0 00",
                  {in_ready, coeff_we, busy, done, err}, coeff_sel, coeff_out);
      end
      repeat (8) @(negedge clk);
      exp_q = '{{2'd0, 8'h01}, {2'd1, 8'h02}};
      n_cmp++;
      if (act_q.size() !== exp_q.size() || done_cnt !== 0) begin
         n_fail++;
         $display("FAIL midrst_abandon: %0d writes %0d done, required %0d writes 0 done",
                  act_q.size(), done_cnt, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL midrst_write%0d: got %h, required %h", i, act_q[i], exp_q[i]);
            end
         end
      end
      clear_logs();
      send_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D);
      wait_done();
      exp_q = '{{2'd0, 8'h0A}, {2'd1, 8'h0B}, {2'd2, 8'h0C}, {2'd3, 8'h0D}};
      n_cmp++;
      if (act_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL midrst_next_count: %0d writes, required %0d", act_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL midrst_next_write%0d: got %h, required %h", i, act_q[i], exp_q[i]);
            end
         end
      end
   endtask

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      clear_logs();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      send_byte(8'h05);
      in_valid = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || coeff_we !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL csum_bad: err=%0b we=%0b busy=%0b, required 1 0 0", err, coeff_we, busy);
      end
      repeat (6) @(negedge clk);
      n_cmp++;
      if (act_q.size() !== 0 || done_cnt !== 0 || err !== 1'b1) begin
         n_fail++;
         $display("FAIL csum_no_commit: %0d writes %0d done err=%0b, required 0 0 1",
                  act_q.size(), done_cnt, err);
      end
      send_byte(8'hA5);
      in_valid = 1'b0;
      n_cmp++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL csum_err_clear: err=%0b, required 0", err);
      end
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      send_byte(8'h04);
      in_valid = 1'b0;
      wait_done();
      n_cmp++;
      if (act_q.size() !== 4 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL csum_good: %0d writes err=%0b, required 4 0", act_q.size(), err);
      end
   endtask
`endif

   initial begin
      in_valid = 1'b0;
      in_data  = 8'h00;
      rst      = 1'b1;
      test_reset();
      test_basic();
      test_discard();
      test_gap();
      test_header_as_data();
      test_reset_mid_commit();
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Byte-stream coefficient loader sitting directly upstream of the FIR coefficient register bank. It hunts for a header byte on a valid/ready byte input and collects NUM_COEFF coefficient bytes into a shadow buffer. It then commits them to the register bank as a burst of single-cycle write strobes, one per cycle with ascending select. A partially received frame never reaches the FIR, so coefficients change atomically from the filter's point of view.

## Interface
- NUM_COEFF, 4, number of coefficients per frame (≥2)
- SIZE, 8, coefficient width in bits (1..8); the low SIZE bits of each byte are used
- HEADER, 8'hA5, frame start byte
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  8  incoming byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte this cycle
- coeff_out  out  SIZE  coefficient value to the register bank
- coeff_sel  out  $clog2(NUM_COEFF)  register bank select
- coeff_we  out  1  register bank write enable, one-cycle strobe per coefficient
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse after the last commit write
- err  out  1  sticky frame error flag; cleared on next accepted HEADER or on rst

## Operation
- Byte transfer occurs on any cycle with in_valid && in_ready; no other cycle consumes a byte.
- States:
  - IDLE: in_ready=1. HEADER → LOAD, clear err, idx=0. Any other byte is discarded; stay in IDLE.
  - LOAD: in_ready=1. Each accepted byte goes to shadow[idx], idx++. Bytes equal to HEADER are data here, not resync. The byte at idx=NUM_COEFF-1 → CHECK if the macro is defined, else → COMMIT.
  - CHECK: in_ready=1. Accepted byte compared with the XOR of all shadow bytes (full 8 bits). Match → COMMIT; mismatch → set err, → IDLE, no writes.
  - COMMIT: in_ready=0. For k=0..NUM_COEFF-1 on consecutive cycles: coeff_we=1, coeff_sel=k, coeff_out=shadow[k][SIZE-1:0]. After k=NUM_COEFF-1 → DONE.
  - DONE: done=1 for one cycle, in_ready=0, → IDLE.
- coeff_out and coeff_sel are registered and hold their last values when coeff_we=0.
- The shadow buffer is overwritten only by the next frame; there is no partial commit.
- in_valid low in LOAD or CHECK: the FSM waits indefinitely with no timeout; the frame resumes when bytes arrive.
- rst at any point, including mid-COMMIT: → IDLE next edge. The remaining writes are abandoned; writes already issued stand.

## Timing
- Reset values: in_ready=0 in the reset cycle, then 1 (IDLE); coeff_out=0, coeff_sel=0, coeff_we=0, busy=0, done=0, err=0. Shadow cleared to 0.
- The last frame byte (last coefficient, or checksum) is accepted at edge t.
  - coeff_we is high for cycles t+1 .. t+NUM_COEFF.
  - done is high in cycle t+NUM_COEFF+1.
  - in_ready returns high in cycle t+NUM_COEFF+2.
- Minimum frame period with continuous valid is 1+NUM_COEFF(+1 with checksum)+NUM_COEFF+1 cycles.
- in_ready depends only on state (registered); there is no combinational path from in_valid.
- err is set in the cycle after the mismatching checksum byte is accepted.

## Configuration
- FIR_COEFF_LOADER_CHECKSUM_EN defined:
  - The CHECK state exists, and frame length is NUM_COEFF+2 bytes.
  - err is asserted on a checksum mismatch.
- FIR_COEFF_LOADER_CHECKSUM_EN undefined:
  - The CHECK state is removed; LOAD → COMMIT directly, and frame length is NUM_COEFF+1 bytes.
  - err is tied to 0.

## Structure
- Shared package fir_pkg holds:
  - the loader state enum (IDLE, LOAD, CHECK, COMMIT, DONE);
  - the default HEADER constant 8'hA5;
  - the XOR-reduce checksum function.
- One sub-module, coeff_shadow_bank, holds the NUM_COEFF×8 shadow registers with write index/enable and a read index mux. The FSM and handshake stay in the top module.

## Test plan
- Reset, then send A5 01 02 03 04 (no macro) with continuous valid → coeff_we on 4 consecutive cycles with (sel,out) = (0,01),(1,02),(2,03),(3,04); then done pulses once, busy falls, in_ready rises.
- Send 00 FF A5 10 20 30 40 → 00 and FF are discarded; writes are 10,20,30,40 at sel 0..3.
- Macro defined, send A5 01 02 03 04 04 → 4 writes then done. Send A5 01 02 03 04 05 → no coeff_we, err=1. A following A5 clears err.
- Send A5 11 22 with in_valid dropped for 5 cycles, then 33 44 → the FSM waits in LOAD; writes are 11,22,33,44, and no bytes are accepted during the gap.
- Send A5 A5 A5 A5 A5 → the second through fifth A5 are data; 4 writes of A5.
- Assert rst for one cycle during the second commit write (sel=1) → all outputs return to reset values the next cycle; no further coeff_we; the next valid frame loads normally.
